// File: rtl/crc_pipe_gen.sv
// crc_pipe_gen: pipelined CRC generator/checker. Each stage performs BPS bits of
// polynomial long division; valid/ready on both sides, whole pipeline stalls together.
module crc_pipe_gen #(
  parameter int            K        = 5,
  parameter int            N        = 11,
  parameter logic [K-1:0]  CRC_POLY = K'(5'b00101),
  parameter int            BPS      = 1,
  parameter int            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N+K-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [K-1:0]     crc_out,
  output logic             crc_ok,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int W      = N + K;
  localparam int S      = (N + BPS - 1) / BPS;
  localparam int B_LAST = N - (S - 1) * BPS;

  // Divides out the message bits owned by stage s, MSB first. Bits already
  // reduced are left at zero, so the live width shrinks stage by stage.
  function automatic logic [W-1:0] reduce_stage(input logic [W-1:0] r_in, input int s);
    logic [W-1:0] r;
    int top;
    int b;
    int p;
    r   = r_in;
    top = W - 1 - (s - 1) * BPS;
    b   = (s == S) ? B_LAST : BPS;
    for (int j = 0; j < BPS; j++) begin
      p = top - j;
      if (p < K) p = K;
      if (j < b) begin
        if (r[p]) begin
          r[p-1 -: K] = r[p-1 -: K] ^ CRC_POLY;
        end
        r[p] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [S:0]   vld_p;
  logic [S:0]   mode_p;
  logic [W-1:0] data_p [0:S];
  logic [W-1:0] red    [1:S];
  logic         adv;

  assign adv      = !vld_p[S] | out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int s = 1; s <= S; s++) begin
      red[s] = reduce_stage(data_p[s-1], s);
    end
  end

  // Stage 0 captures the raw codeword; stages 1..S each reduce one slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p  <= '0;
      mode_p <= '0;
      for (int s = 0; s <= S; s++) begin
        data_p[s] <= '0;
      end
    end else if (adv) begin
      vld_p[0] <= in_valid;
      if (in_valid) begin
        mode_p[0] <= in_mode;
        data_p[0] <= {in_data[W-1:K], in_mode ? in_data[K-1:0] : {K{1'b0}}};
      end
      for (int s = 1; s <= S; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) begin
          mode_p[s] <= mode_p[s-1];
          data_p[s] <= red[s];
        end
      end
    end
  end

  // Output stage: after full reduction every message bit of data_p[S] is zero,
  // so the whole word being zero is the same as the remainder being zero.
  assign out_valid = vld_p[S];
  assign out_mode  = mode_p[S];
  assign crc_out   = data_p[S][K-1:0];
  assign crc_ok    = mode_p[S] & ~|data_p[S];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_mode && !crc_ok) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_crc_pipe_gen.sv
// Bench for crc_pipe_gen: three instances (BPS=1, BPS=4, BPS=11 with a 2-bit counter)
// checked against table vectors and a long-division reference model.
`timescale 1ns/1ps
module tb_crc_pipe_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [3];
  logic        in_mode   [3];
  logic        out_ready [3];
  logic [15:0] in_data   [3];

  wire         in_ready_w  [3];
  wire         out_valid_w [3];
  wire         out_mode_w  [3];
  wire         crc_ok_w    [3];
  wire  [4:0]  crc_out_w   [3];
  wire  [15:0] err_cnt_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPS_G = (g == 0) ? 1 : ((g == 1) ? 4 : 11);
    localparam int CW_G  = (g == 2) ? 2 : 16;
    logic            rdy, vld, md, ok;
    logic [4:0]      co;
    logic [CW_G-1:0] ec;
    crc_pipe_gen #(
      .K(5), .N(11), .CRC_POLY(5'b00101), .BPS(BPS_G), .CNT_W(CW_G)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(rdy), .in_mode(in_mode[g]), .in_data(in_data[g]),
      .out_valid(vld), .out_ready(out_ready[g]), .out_mode(md),
      .crc_out(co), .crc_ok(ok), .err_cnt(ec)
    );
    assign in_ready_w[g]  = rdy;
    assign out_valid_w[g] = vld;
    assign out_mode_w[g]  = md;
    assign crc_ok_w[g]    = ok;
    assign crc_out_w[g]   = co;
    assign err_cnt_w[g]   = 16'(ec);
  end

  typedef struct {
    logic        mode;
    logic [10:0] msg;
    logic [4:0]  fld;
    logic [4:0]  exp_crc;
    logic        exp_ok;
  } vec_t;

  typedef struct {
    logic       mode;
    logic [4:0] crc;
  } exp_t;

  int n_chk;
  int n_err;
  int lat_exp [3];
  int cnt_max [3];
  int exp_err [3];
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: polynomial long division on an integer, x^5+x^2+1 = 0x25.
  function automatic logic [4:0] model_crc(input logic [10:0] msg, input logic [4:0] fld, input logic mode);
    int v;
    v = (int'(msg) << 5) | (mode ? int'(fld) : 0);
    for (int i = 15; i >= 5; i--) begin
      if (v[i]) v = v ^ (32'h25 << (i - 5));
    end
    return v[4:0];
  endfunction

  task automatic bump_err(input int d);
    if (exp_err[d] < cnt_max[d]) exp_err[d] = exp_err[d] + 1;
  endtask

  task automatic one_beat(input int d, input logic mode, input logic [10:0] msg, input logic [4:0] fld,
                          input logic [4:0] ecrc, input logic eok, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_mode[d]   = mode;
    in_data[d]   = {msg, fld};
    #1 check({tag, " in_ready"}, 32'(in_ready_w[d]), 32'd1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = out_valid_w[d];
    end
    check({tag, " seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(lat_exp[d]));
    check({tag, " crc"}, 32'(crc_out_w[d]), 32'(ecrc));
    check({tag, " ok"}, 32'(crc_ok_w[d]), 32'(eok));
    check({tag, " mode"}, 32'(out_mode_w[d]), 32'(mode));
    if (mode && !eok) bump_err(d);
    @(posedge clk);
    @(negedge clk);
    check({tag, " drained"}, 32'(out_valid_w[d]), 32'd0);
    check({tag, " err_cnt"}, 32'(err_cnt_w[d]), 32'(exp_err[d]));
  endtask

  task automatic stream(input int d, input int nb, input bit rnd);
    exp_t        q[$];
    exp_t        e;
    int          sent, got, cyc, last_cyc;
    bit          stalled;
    logic [4:0]  s_crc;
    logic        s_ok, s_md, md;
    logic [10:0] msg;
    logic [4:0]  fld;
    sent = 0; got = 0; cyc = 0; last_cyc = 0; stalled = 1'b0;
    s_crc = '0; s_ok = 1'b0; s_md = 1'b0; md = 1'b0; msg = '0; fld = '0;
    while (got < nb && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall valid", 32'(out_valid_w[d]), 32'd1);
        check("stall crc", 32'(crc_out_w[d]), 32'(s_crc));
        check("stall ok", 32'(crc_ok_w[d]), 32'(s_ok));
        check("stall mode", 32'(out_mode_w[d]), 32'(s_md));
      end
      out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < nb && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (!rnd && sent < 3) begin
          md  = 1'b0;
          msg = (sent == 0) ? 11'h400 : ((sent == 1) ? 11'h000 : 11'h001);
          fld = 5'h00;
        end else begin
          md  = 1'($urandom_range(0, 1));
          msg = 11'($urandom_range(0, 2047));
          fld = ($urandom_range(0, 1) == 1) ? model_crc(msg, 5'h00, 1'b0) : 5'($urandom_range(0, 31));
        end
        in_valid[d] = 1'b1;
        in_mode[d]  = md;
        in_data[d]  = {msg, fld};
      end else begin
        in_valid[d] = 1'b0;
      end
      #1;
      check("in_ready", 32'(in_ready_w[d]), 32'(!out_valid_w[d] || out_ready[d]));
      if (in_valid[d] && in_ready_w[d]) begin
        e.mode = md;
        e.crc  = model_crc(msg, fld, md);
        q.push_back(e);
        sent++;
      end
      if (out_valid_w[d] && out_ready[d]) begin
        if (q.size() == 0) begin
          check("spurious out", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("stream crc", 32'(crc_out_w[d]), 32'(e.crc));
          check("stream ok", 32'(crc_ok_w[d]), 32'(e.mode && e.crc == 5'h00));
          check("stream mode", 32'(out_mode_w[d]), 32'(e.mode));
          if (e.mode && e.crc != 5'h00) bump_err(d);
        end
        if (!rnd && got > 0) check("full rate gap", 32'(cyc - last_cyc), 32'd1);
        last_cyc = cyc;
        got++;
      end
      stalled = out_valid_w[d] && !out_ready[d];
      s_crc = crc_out_w[d];
      s_ok  = crc_ok_w[d];
      s_md  = out_mode_w[d];
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    check("stream count", 32'(got), 32'(nb));
    @(negedge clk);
    check("stream err_cnt", err_cnt_w[d], 32'(exp_err[d]));
  endtask

  initial begin
    int stale [3];
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    lat_exp = '{11, 3, 1};
    cnt_max = '{65535, 65535, 3};
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_mode[d]   = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
      exp_err[d]   = 0;
      stale[d]     = 0;
    end
    tbl[0] = '{1'b0, 11'h001, 5'h00,    5'b00101, 1'b0};
    tbl[1] = '{1'b0, 11'h400, 5'h00,    5'b11111, 1'b0};
    tbl[2] = '{1'b0, 11'h000, 5'h1f,    5'b00000, 1'b0};
    tbl[3] = '{1'b1, 11'h001, 5'b00101, 5'b00000, 1'b1};
    tbl[4] = '{1'b1, 11'h001, 5'b00100, 5'b00001, 1'b0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset out_valid", 32'(out_valid_w[d]), 32'd0);
      check("reset crc_out", 32'(crc_out_w[d]), 32'd0);
      check("reset crc_ok", 32'(crc_ok_w[d]), 32'd0);
      check("reset out_mode", 32'(out_mode_w[d]), 32'd0);
      check("reset err_cnt", err_cnt_w[d], 32'd0);
      check("reset in_ready", 32'(in_ready_w[d]), 32'd1);
    end
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 5; v++) begin
        one_beat(d, tbl[v].mode, tbl[v].msg, tbl[v].fld, tbl[v].exp_crc, tbl[v].exp_ok,
                 $sformatf("vec%0d/dut%0d", v, d));
      end
    end

    for (int d = 0; d < 3; d++) stream(d, 8, 1'b0);
    for (int d = 0; d < 3; d++) stream(d, 20, 1'b1);

    // Reset with beats in flight, outputs held back so the pipelines fill.
    @(negedge clk);
    for (int d = 0; d < 3; d++) out_ready[d] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d] = 1'b1;
        in_mode[d]  = 1'b1;
        in_data[d]  = 16'($urandom_range(0, 65535)) | 16'h0001;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("inflight rst out_valid", 32'(out_valid_w[d]), 32'd0);
      check("inflight rst err_cnt", err_cnt_w[d], 32'd0);
      check("inflight rst crc_out", 32'(crc_out_w[d]), 32'd0);
      check("inflight rst crc_ok", 32'(crc_ok_w[d]), 32'd0);
      exp_err[d]   = 0;
      out_ready[d] = 1'b1;
    end
    repeat (25) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (out_valid_w[d]) stale[d]++;
    end
    for (int d = 0; d < 3; d++) check("stale results", 32'(stale[d]), 32'd0);

    // Five failing checks on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      one_beat(2, 1'b1, 11'h001, 5'b00100, 5'b00001, 1'b0, $sformatf("sat%0d", i));
    end
    check("err_cnt saturated", err_cnt_w[2], 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
